// File: rtl/router_pkg.sv
// Shared router types: payload beat type and output-arbiter state encoding.
package router_pkg;

  localparam int ROUT_MSG_W = 128;
  typedef logic [ROUT_MSG_W-1:0] rout_msg_t;

  typedef enum logic [0:0] {ARB_IDLE, ARB_BUSY} arb_state_e;

  parameter int ARB_TIMEOUT_CYCLES = 64;

endpackage

// File: rtl/router_rr_pick.sv
// Combinational round-robin picker: first asserted req at or above ptr, wrapping modulo NUM_PORTS.
module router_rr_pick #(
  parameter int NUM_PORTS = 4,
  parameter int IDX_W     = 2
) (
  input  logic [NUM_PORTS-1:0] req,
  input  logic [IDX_W-1:0]     ptr,
  output logic                 found,
  output logic [IDX_W-1:0]     idx
);

  function automatic logic [IDX_W-1:0] wrap_add(input logic [IDX_W-1:0] base, input int off);
    int s;
    s = int'(base) + off;
    if (s >= NUM_PORTS) s = s - NUM_PORTS;
    return IDX_W'(s);
  endfunction

  logic [IDX_W-1:0] w_cand;

  // Scan farthest-first so the closest requester at/after ptr overwrites and wins.
  always_comb begin
    found  = 1'b0;
    idx    = '0;
    w_cand = '0;
    for (int k = NUM_PORTS - 1; k >= 0; k--) begin
      w_cand = wrap_add(ptr, k);
      if (req[w_cand]) begin
        found = 1'b1;
        idx   = w_cand;
      end
    end
  end

endmodule

// File: rtl/router_out_arbiter.sv
// Per-output packet arbiter: round-robin grant held until tlast.
// Optional stall watchdog enabled by defining ROUTER_ARB_TIMEOUT_EN.
module router_out_arbiter
  import router_pkg::*;
#(
  parameter int NUM_PORTS      = 4,
  parameter int PORT_WIDTH     = 128,
  parameter int TID_W          = 8,
  parameter int TIMEOUT_CYCLES = ARB_TIMEOUT_CYCLES
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic [NUM_PORTS-1:0]            in_tvalid,
  output logic [NUM_PORTS-1:0]            in_tready,
  input  logic [NUM_PORTS*PORT_WIDTH-1:0] in_tdata,
  input  logic [NUM_PORTS-1:0]            in_tlast,
  output logic                            out_tvalid,
  input  logic                            out_tready,
  output logic [PORT_WIDTH-1:0]           out_tdata,
  output logic                            out_tlast,
  output logic [TID_W-1:0]                out_tid,
  output logic [NUM_PORTS-1:0]            grant,
  output logic                            err_timeout
);

  localparam int IDX_W = (NUM_PORTS > 1) ? $clog2(NUM_PORTS) : 1;

  arb_state_e       r_state, w_state_next;
  logic [IDX_W-1:0] r_ptr, w_ptr_next;
  logic [IDX_W-1:0] r_gnt_idx, w_gnt_idx_next;
  logic [IDX_W-1:0] w_pick_idx, w_gnt_inc;
  logic             w_pick_found, w_busy, w_hs, w_timeout;
  rout_msg_t        w_msg [NUM_PORTS];

  generate
    for (genvar gi = 0; gi < NUM_PORTS; gi++) begin : g_msg
      assign w_msg[gi] = in_tdata[gi*PORT_WIDTH +: PORT_WIDTH];
    end
  endgenerate

  router_rr_pick #(
    .NUM_PORTS (NUM_PORTS),
    .IDX_W     (IDX_W)
  ) u_pick (
    .req   (in_tvalid),
    .ptr   (r_ptr),
    .found (w_pick_found),
    .idx   (w_pick_idx)
  );

  assign w_busy    = (r_state == ARB_BUSY);
  assign w_gnt_inc = (r_gnt_idx == IDX_W'(NUM_PORTS - 1)) ? '0 : r_gnt_idx + IDX_W'(1);

  // Granted input is forwarded combinationally; nothing moves while idle.
  always_comb begin
    in_tready = '0;
    grant     = '0;
    if (w_busy) begin
      in_tready[r_gnt_idx] = out_tready;
      grant[r_gnt_idx]     = 1'b1;
    end
  end

  assign out_tvalid = w_busy & in_tvalid[r_gnt_idx];
  assign out_tdata  = w_msg[r_gnt_idx];
  assign out_tlast  = in_tlast[r_gnt_idx];
  assign out_tid    = TID_W'(r_gnt_idx);
  assign w_hs       = out_tvalid & out_tready;

  always_comb begin
    w_state_next   = r_state;
    w_ptr_next     = r_ptr;
    w_gnt_idx_next = r_gnt_idx;
    case (r_state)
      ARB_IDLE: begin
        if (w_pick_found) begin
          w_gnt_idx_next = w_pick_idx;
          w_state_next   = ARB_BUSY;
        end
      end
      ARB_BUSY: begin
        if ((w_hs && out_tlast) || w_timeout) begin
          w_state_next = ARB_IDLE;
          w_ptr_next   = w_gnt_inc;
        end
      end
      default: w_state_next = ARB_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state   <= ARB_IDLE;
      r_ptr     <= '0;
      r_gnt_idx <= '0;
    end else begin
      r_state   <= w_state_next;
      r_ptr     <= w_ptr_next;
      r_gnt_idx <= w_gnt_idx_next;
    end
  end

`ifdef ROUTER_ARB_TIMEOUT_EN
  localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);

  logic [CNT_W-1:0] r_stall_cnt;
  logic             r_err_timeout;

  // Fires on the TIMEOUT_CYCLES-th consecutive cycle the granted input has no beat.
  assign w_timeout = w_busy & ~in_tvalid[r_gnt_idx] &
                     (r_stall_cnt == CNT_W'(TIMEOUT_CYCLES - 1));

  always_ff @(posedge clk) begin
    if (rst) begin
      r_stall_cnt   <= '0;
      r_err_timeout <= 1'b0;
    end else begin
      r_err_timeout <= w_timeout;
      if (!w_busy || in_tvalid[r_gnt_idx] || w_timeout) begin
        r_stall_cnt <= '0;
      end else begin
        r_stall_cnt <= r_stall_cnt + CNT_W'(1);
      end
    end
  end

  assign err_timeout = r_err_timeout;
`else
  logic w_unused_timeout;
  assign w_unused_timeout = (TIMEOUT_CYCLES > 0);
  assign w_timeout        = 1'b0;
  assign err_timeout      = 1'b0;
`endif

endmodule

// File: tb/tb_router_out_arbiter.sv
// Scoreboard bench for router_out_arbiter: per-input beat sources, expected-beat queue, per-scenario tasks.
module tb_router_out_arbiter;
  import router_pkg::*;

  localparam int NP = 4;
  localparam int PW = 128;
  localparam int TW = 8;
  localparam int TO = 8;

  logic                 clk = 1'b0;
  logic                 rst = 1'b1;
  logic [NP-1:0]        in_tvalid = '0;
  logic [NP-1:0]        in_tready;
  logic [NP*PW-1:0]     in_tdata = '0;
  logic [NP-1:0]        in_tlast = '0;
  logic                 out_tvalid;
  logic                 out_tready = 1'b1;
  logic [PW-1:0]        out_tdata;
  logic                 out_tlast;
  logic [TW-1:0]        out_tid;
  logic [NP-1:0]        grant;
  logic                 err_timeout;

  always #5 clk = ~clk;

  router_out_arbiter #(
    .NUM_PORTS      (NP),
    .PORT_WIDTH     (PW),
    .TID_W          (TW),
    .TIMEOUT_CYCLES (TO)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .in_tvalid   (in_tvalid),
    .in_tready   (in_tready),
    .in_tdata    (in_tdata),
    .in_tlast    (in_tlast),
    .out_tvalid  (out_tvalid),
    .out_tready  (out_tready),
    .out_tdata   (out_tdata),
    .out_tlast   (out_tlast),
    .out_tid     (out_tid),
    .grant       (grant),
    .err_timeout (err_timeout)
  );

  typedef struct packed {logic v; logic last; logic [PW-1:0] data;} beat_t;
  typedef struct packed {logic [TW-1:0] tid; logic last; logic [PW-1:0] data;} exp_t;

  beat_t         src_q [NP][$];
  exp_t          exp_q [$];
  exp_t          mon_e;
  logic [NP-1:0] pop_r = '0;
  bit            bp_en = 1'b0;
  int            checks = 0;
  int            failures = 0;

  // Monitor: scoreboard compare on each output handshake, and decide which source beats get consumed.
  always @(negedge clk) begin
    for (int i = 0; i < NP; i++) begin
      pop_r[i] = !rst && (src_q[i].size() > 0) &&
                 ((in_tvalid[i] && in_tready[i]) || (!src_q[i][0].v && !in_tvalid[i]));
    end
    if (!rst && out_tvalid && out_tready) begin
      checks++;
      if (exp_q.size() == 0) begin
        failures++;
        $display("FAIL scoreboard_extra: got tid=%0d last=%0b data=%h, required no beat",
                 out_tid, out_tlast, out_tdata);
      end else begin
        mon_e = exp_q.pop_front();
        if ({out_tid, out_tlast, out_tdata} !== mon_e) begin
          failures++;
          $display("FAIL scoreboard_beat: got tid=%0d last=%0b data=%h, required tid=%0d last=%0b data=%h",
                   out_tid, out_tlast, out_tdata, mon_e.tid, mon_e.last, mon_e.data);
        end else begin
          $display("beat tid=%0d last=%0b data=%h", out_tid, out_tlast, out_tdata);
        end
      end
    end
  end

  // Sources: retire consumed beats, then present the head of each queue.
  always @(posedge clk) begin
    #2;
    for (int i = 0; i < NP; i++) begin
      if (pop_r[i] && src_q[i].size() > 0) void'(src_q[i].pop_front());
      if (src_q[i].size() > 0) begin
        in_tvalid[i]          = src_q[i][0].v;
        in_tlast[i]           = src_q[i][0].last;
        in_tdata[i*PW +: PW]  = src_q[i][0].data;
      end else begin
        in_tvalid[i] = 1'b0;
        in_tlast[i]  = 1'b0;
      end
    end
    out_tready = bp_en ? 1'($urandom_range(0, 1)) : 1'b1;
  end

  function automatic logic [PW-1:0] rand_data();
    return {$urandom(), $urandom(), $urandom(), $urandom()};
  endfunction

  // Queue a packet on one input, with optional bubbles after its first beat, and its expected output.
  task automatic push_pkt(input int port, input int len, input int gap);
    logic [PW-1:0] d;
    for (int b = 0; b < len; b++) begin
      d = rand_data();
      src_q[port].push_back('{1'b1, (b == len - 1), d});
      exp_q.push_back('{TW'(port), (b == len - 1), d});
      if (b == 0) for (int g = 0; g < gap; g++) src_q[port].push_back('{1'b0, 1'b0, '0});
    end
  endtask

  task automatic do_reset();
    @(posedge clk); #1;
    rst = 1'b1;
    for (int i = 0; i < NP; i++) src_q[i].delete();
    exp_q.delete();
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
  endtask

  task automatic wait_drain(input string name, input int budget);
    bit done;
    done = 1'b0;
    for (int c = 0; c < budget && !done; c++) begin
      @(negedge clk);
      done = (exp_q.size() == 0);
      for (int i = 0; i < NP; i++) if (src_q[i].size() != 0) done = 1'b0;
    end
    checks++;
    if (!done) begin
      failures++;
      $display("FAIL %s_drain: %0d expected beats still pending after %0d cycles, required 0",
               name, exp_q.size(), budget);
    end
  endtask

  task automatic test_reset();
    @(posedge clk); #1 rst = 1'b1;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      checks += 4;
      if (out_tvalid !== 1'b0) begin failures++; $display("FAIL reset_out_tvalid: cycle %0d got %b, required 0", c, out_tvalid); end
      if (grant !== 4'b0000)   begin failures++; $display("FAIL reset_grant: cycle %0d got %b, required 0000", c, grant); end
      if (in_tready !== 4'b0000) begin failures++; $display("FAIL reset_in_tready: cycle %0d got %b, required 0000", c, in_tready); end
      if (err_timeout !== 1'b0) begin failures++; $display("FAIL reset_err_timeout: cycle %0d got %b, required 0", c, err_timeout); end
    end
    $display("test_reset done");
  endtask

  task automatic test_single_packet();
    @(posedge clk); #1;
    push_pkt(2, 3, 0);
    @(negedge clk);
    checks++;
    if (grant !== 4'b0000) begin failures++; $display("FAIL single_arb_cycle_grant: got %b, required 0000", grant); end
    for (int c = 1; c <= 3; c++) begin
      @(negedge clk);
      checks += 3;
      if (grant !== 4'b0100)   begin failures++; $display("FAIL single_grant: cycle %0d got %b, required 0100", c, grant); end
      if (out_tvalid !== 1'b1) begin failures++; $display("FAIL single_out_tvalid: cycle %0d got %b, required 1", c, out_tvalid); end
      if (out_tid !== 8'd2)    begin failures++; $display("FAIL single_out_tid: cycle %0d got %0d, required 2", c, out_tid); end
    end
    @(negedge clk);
    checks++;
    if (grant !== 4'b0000) begin failures++; $display("FAIL single_release: got %b, required 0000", grant); end
    // With ptr at 3, input 3 must beat input 1.
    @(posedge clk); #1;
    push_pkt(3, 1, 0);
    push_pkt(1, 1, 0);
    wait_drain("single_ptr3", 40);
    $display("test_single_packet done");
  endtask

  task automatic test_round_robin();
    logic [NP-1:0] tbl [11];
    tbl = '{4'h0, 4'h1, 4'h0, 4'h2, 4'h0, 4'h4, 4'h0, 4'h8, 4'h0, 4'h1, 4'h0};
    do_reset();
    @(posedge clk); #1;
    for (int i = 0; i < NP; i++) push_pkt(i, 1, 0);
    push_pkt(0, 1, 0);
    for (int c = 0; c < 11; c++) begin
      @(negedge clk);
      checks++;
      if (grant !== tbl[c]) begin failures++; $display("FAIL rr_grant: cycle %0d got %b, required %b", c, grant, tbl[c]); end
    end
    wait_drain("rr", 40);
    $display("test_round_robin done");
  endtask

  task automatic test_hold_grant();
    do_reset();
    @(posedge clk); #1;
    push_pkt(1, 3, 5);
    push_pkt(3, 1, 0);
    @(negedge clk);
    for (int c = 1; c <= 8; c++) begin
      @(negedge clk);
      checks += 2;
      if (grant !== 4'b0010)     begin failures++; $display("FAIL hold_grant: cycle %0d got %b, required 0010", c, grant); end
      if (in_tready[3] !== 1'b0) begin failures++; $display("FAIL hold_ready3: cycle %0d got %b, required 0", c, in_tready[3]); end
    end
    wait_drain("hold", 40);
    $display("test_hold_grant done");
  endtask

  task automatic test_reset_mid_packet();
    do_reset();
    @(posedge clk); #1;
    push_pkt(2, 1, 0);
    wait_drain("rstmid_pre", 40);
    @(posedge clk); #1;
    push_pkt(0, 4, 0);
    @(posedge clk);
    @(posedge clk); #1;
    rst = 1'b1;
    @(negedge clk);
    checks++;
    if (exp_q.size() !== 3) begin failures++; $display("FAIL rstmid_beats_before: %0d pending, required 3", exp_q.size()); end
    @(posedge clk); #1;
    rst = 1'b0;
    for (int i = 0; i < NP; i++) src_q[i].delete();
    exp_q.delete();
    @(negedge clk);
    checks += 2;
    if (grant !== 4'b0000)   begin failures++; $display("FAIL rstmid_grant: got %b, required 0000", grant); end
    if (out_tvalid !== 1'b0) begin failures++; $display("FAIL rstmid_out_tvalid: got %b, required 0", out_tvalid); end
    // ptr must be back at 0, so input 0 wins over input 3.
    @(posedge clk); #1;
    push_pkt(0, 1, 0);
    push_pkt(3, 1, 0);
    wait_drain("rstmid_post", 40);
    $display("test_reset_mid_packet done");
  endtask

  task automatic test_backpressure();
    do_reset();
    bp_en = 1'b1;
    @(posedge clk); #1;
    for (int i = 0; i < NP; i++) push_pkt(i, 2, 0);
    wait_drain("bp", 300);
    bp_en = 1'b0;
    @(posedge clk);
    $display("test_backpressure done");
  endtask

  task automatic test_timeout();
    logic [PW-1:0] d0, d1;
    do_reset();
    d0 = rand_data();
    d1 = rand_data();
    @(posedge clk); #1;
    src_q[0].push_back('{1'b1, 1'b0, d0});
    exp_q.push_back('{TW'(0), 1'b0, d0});
    src_q[1].push_back('{1'b1, 1'b1, d1});
`ifdef ROUTER_ARB_TIMEOUT_EN
    begin
      int err_cyc, err_cnt;
      logic [NP-1:0] gnt_after;
      err_cyc = -1; err_cnt = 0; gnt_after = '0;
      exp_q.push_back('{TW'(1), 1'b1, d1});
      @(negedge clk);
      for (int c = 1; c <= 30; c++) begin
        @(negedge clk);
        if (err_timeout) begin err_cnt++; if (err_cyc < 0) err_cyc = c; end
        if (err_cyc >= 0 && gnt_after == '0 && grant != '0) gnt_after = grant;
      end
      checks += 3;
      if (err_cyc !== 10)       begin failures++; $display("FAIL timeout_cycle: got %0d, required 10", err_cyc); end
      if (err_cnt !== 1)        begin failures++; $display("FAIL timeout_pulse_len: got %0d, required 1", err_cnt); end
      if (gnt_after !== 4'b0010) begin failures++; $display("FAIL timeout_next_grant: got %b, required 0010", gnt_after); end
    end
`else
    @(negedge clk);
    for (int c = 1; c <= 20; c++) begin
      @(negedge clk);
      checks += 2;
      if (grant !== 4'b0001)    begin failures++; $display("FAIL notimeout_grant: cycle %0d got %b, required 0001", c, grant); end
      if (err_timeout !== 1'b0) begin failures++; $display("FAIL notimeout_err: cycle %0d got %b, required 0", c, err_timeout); end
    end
    @(posedge clk); #1;
    d0 = rand_data();
    src_q[0].push_back('{1'b1, 1'b1, d0});
    exp_q.push_back('{TW'(0), 1'b1, d0});
    exp_q.push_back('{TW'(1), 1'b1, d1});
`endif
    wait_drain("timeout", 60);
    $display("test_timeout done");
  endtask

  initial begin
    test_reset();
    test_single_packet();
    test_round_robin();
    test_hold_grant();
    test_reset_mid_packet();
    test_backpressure();
    test_timeout();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1, "watchdog expired");
  end

endmodule
